// File: rtl/avalon_packetizer.sv
// Avalon-ST packetizer: frames an unframed stream of data words into packets
// whose length in bytes comes from a separate descriptor (msg_len). Data
// passes straight through with zero latency. The packetizer only adds
// sop/eop/empty framing and gates the handshake.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   msg_len[_valid/_rdy] length descriptor in bytes for the next packet
//   raw_data_*          unframed input words (data/valid/rdy)
//   packet_msg_*        framed output (data/valid/sop/eop/empty, rdy from sink)
//   zero_len_err        one-cycle pulse: a zero-length descriptor was dropped
//   pkt_done            one-cycle pulse the cycle after an eop transfer
//
// state   | meaning
// IDLE    | waiting for a length descriptor; data path closed
// IN_MSG  | streaming the words of the current packet straight through
module avalon_packetizer #(
    parameter  int DATA_WIDTH_IN_BYTES = 16,
    parameter  int LEN_WIDTH           = 16,
    localparam int EMPTY_W             = $clog2(DATA_WIDTH_IN_BYTES),
    localparam int DATA_W              = DATA_WIDTH_IN_BYTES * 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic                 msg_len_valid,
    output logic                 msg_len_rdy,

    input  logic [DATA_W-1:0]    raw_data_data,
    input  logic                 raw_data_valid,
    output logic                 raw_data_rdy,

    output logic [DATA_W-1:0]    packet_msg_data,
    output logic                 packet_msg_valid,
    output logic                 packet_msg_sop,
    output logic                 packet_msg_eop,
    output logic [EMPTY_W-1:0]   packet_msg_empty,
    input  logic                 packet_msg_rdy,

    output logic                 zero_len_err,
    output logic                 pkt_done
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_MSG = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH:0]   words_left_q, words_left_d;
    logic [EMPTY_W-1:0]   last_empty_q, last_empty_d;
    logic                 first_q, first_d;
    logic                 zero_len_err_d;
    logic                 pkt_done_d;

    // One extra bit so rounding up the largest msg_len cannot wrap.
    logic [LEN_WIDTH:0]   len_round;
    logic [LEN_WIDTH:0]   words_ceil;
    logic [EMPTY_W-1:0]   empty_calc;
    logic                 last_word;

    always_comb begin
        len_round  = {1'b0, msg_len} + (LEN_WIDTH+1)'(DATA_WIDTH_IN_BYTES - 1);
        words_ceil = len_round >> EMPTY_W;
        // Negating the low bits modulo the word size gives the unused byte
        // count of the final word, and 0 when the length is word-aligned.
        empty_calc = EMPTY_W'(0) - msg_len[EMPTY_W-1:0];
        last_word  = (words_left_q == (LEN_WIDTH+1)'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            last_empty_q <= '0;
            first_q      <= 1'b0;
            zero_len_err <= 1'b0;
            pkt_done     <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            last_empty_q <= last_empty_d;
            first_q      <= first_d;
            zero_len_err <= zero_len_err_d;
            pkt_done     <= pkt_done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        words_left_d     = words_left_q;
        last_empty_d     = last_empty_q;
        first_d          = first_q;
        zero_len_err_d   = 1'b0;
        pkt_done_d       = 1'b0;
        msg_len_rdy      = 1'b0;
        raw_data_rdy     = 1'b0;
        packet_msg_data  = raw_data_data;
        packet_msg_valid = 1'b0;
        packet_msg_sop   = 1'b0;
        packet_msg_eop   = 1'b0;
        packet_msg_empty = '0;

        case (state_q)
            IDLE: begin
                msg_len_rdy = 1'b1;
                if (msg_len_valid) begin
                    if (msg_len == '0) begin
                        zero_len_err_d = 1'b1;
                    end else begin
                        words_left_d = words_ceil;
                        last_empty_d = empty_calc;
                        first_d      = 1'b1;
                        state_d      = IN_MSG;
                    end
                end
            end

            IN_MSG: begin
                packet_msg_valid = raw_data_valid;
                raw_data_rdy     = packet_msg_rdy;
                // Framing is gated by valid so idle cycles never show sop/eop.
                packet_msg_sop   = raw_data_valid & first_q;
                packet_msg_eop   = raw_data_valid & last_word;
                packet_msg_empty = packet_msg_eop ? last_empty_q : '0;
                if (raw_data_valid && packet_msg_rdy) begin
                    words_left_d = words_left_q - (LEN_WIDTH+1)'(1);
                    first_d      = 1'b0;
                    if (last_word) begin
                        state_d    = IDLE;
                        pkt_done_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_packetizer.sv
module tb_avalon_packetizer;

    localparam int DWB = 16;
    localparam int LW  = 16;
    localparam int EW  = 4;
    localparam int DW  = DWB * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] msg_len;
    logic          msg_len_valid;
    logic          msg_len_rdy;
    logic [DW-1:0] raw_data_data;
    logic          raw_data_valid;
    logic          raw_data_rdy;
    logic [DW-1:0] packet_msg_data;
    logic          packet_msg_valid;
    logic          packet_msg_sop;
    logic          packet_msg_eop;
    logic [EW-1:0] packet_msg_empty;
    logic          packet_msg_rdy;
    logic          zero_len_err;
    logic          pkt_done;

    int checks   = 0;
    int failures = 0;

    avalon_packetizer #(
        .DATA_WIDTH_IN_BYTES(DWB),
        .LEN_WIDTH          (LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .msg_len         (msg_len),
        .msg_len_valid   (msg_len_valid),
        .msg_len_rdy     (msg_len_rdy),
        .raw_data_data   (raw_data_data),
        .raw_data_valid  (raw_data_valid),
        .raw_data_rdy    (raw_data_rdy),
        .packet_msg_data (packet_msg_data),
        .packet_msg_valid(packet_msg_valid),
        .packet_msg_sop  (packet_msg_sop),
        .packet_msg_eop  (packet_msg_eop),
        .packet_msg_empty(packet_msg_empty),
        .packet_msg_rdy  (packet_msg_rdy),
        .zero_len_err    (zero_len_err),
        .pkt_done        (pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] len;
        int            words;
        logic [EW-1:0] empty;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input logic [LW-1:0] len, input int w);
        logic [15:0] tag;
        tag = len ^ 16'(w * 3 + 1);
        return {8{tag}};
    endfunction

    // Starts at a negedge, ends at a negedge with the FSM in IN_MSG.
    task automatic send_desc(input logic [LW-1:0] len);
        msg_len       = len;
        msg_len_valid = 1'b1;
        #1;
        check("desc_rdy_idle", DW'(msg_len_rdy), DW'(1));
        @(negedge clk);
        msg_len_valid = 1'b0;
        #1;
        check("desc_rdy_in_msg", DW'(msg_len_rdy), DW'(0));
        @(negedge clk);
    endtask

    // Drives one word with rdy=1 and checks the framing on it.
    task automatic push_word(input logic [LW-1:0] len, input int w, input int words,
                             input logic [EW-1:0] exp_empty);
        logic last;
        last           = (w == words - 1);
        raw_data_valid = 1'b1;
        raw_data_data  = pattern(len, w);
        packet_msg_rdy = 1'b1;
        #1;
        check("word_valid", DW'(packet_msg_valid), DW'(1));
        check("word_data",  packet_msg_data, pattern(len, w));
        check("word_sop",   DW'(packet_msg_sop), DW'(w == 0));
        check("word_eop",   DW'(packet_msg_eop), DW'(last));
        check("word_empty", DW'(packet_msg_empty), last ? DW'(exp_empty) : DW'(0));
        check("word_rawrdy", DW'(raw_data_rdy), DW'(1));
        @(negedge clk);
    endtask

    task automatic finish_pkt();
        raw_data_valid = 1'b0;
        #1;
        check("pkt_done_pulse", DW'(pkt_done), DW'(1));
        check("idle_valid",     DW'(packet_msg_valid), DW'(0));
        check("idle_len_rdy",   DW'(msg_len_rdy), DW'(1));
        @(negedge clk);
        #1;
        check("pkt_done_clear", DW'(pkt_done), DW'(0));
        @(negedge clk);
    endtask

    task automatic run_packet(input logic [LW-1:0] len, input int words, input logic [EW-1:0] exp_empty);
        send_desc(len);
        for (int w = 0; w < words; w++) push_word(len, w, words, exp_empty);
        finish_pkt();
    endtask

    initial begin
        vecs[0] = '{len: 16'd32,    words: 2,    empty: 4'd0};
        vecs[1] = '{len: 16'd17,    words: 2,    empty: 4'd15};
        vecs[2] = '{len: 16'd5,     words: 1,    empty: 4'd11};
        vecs[3] = '{len: 16'd16,    words: 1,    empty: 4'd0};
        vecs[4] = '{len: 16'd1,     words: 1,    empty: 4'd15};
        vecs[5] = '{len: 16'd100,   words: 7,    empty: 4'd12};
        vecs[6] = '{len: 16'd65535, words: 4096, empty: 4'd1};

        rst            = 1'b1;
        msg_len        = '0;
        msg_len_valid  = 1'b0;
        raw_data_data  = '0;
        raw_data_valid = 1'b0;
        packet_msg_rdy = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_len_rdy",  DW'(msg_len_rdy), DW'(1));
        check("rst_valid",    DW'(packet_msg_valid), DW'(0));
        check("rst_sop",      DW'(packet_msg_sop), DW'(0));
        check("rst_eop",      DW'(packet_msg_eop), DW'(0));
        check("rst_empty",    DW'(packet_msg_empty), DW'(0));
        check("rst_raw_rdy",  DW'(raw_data_rdy), DW'(0));
        check("rst_zero_err", DW'(zero_len_err), DW'(0));
        check("rst_pkt_done", DW'(pkt_done), DW'(0));
        rst = 1'b0;
        @(negedge clk);

        // Zero-length descriptor: dropped, single error pulse, no output.
        msg_len        = '0;
        msg_len_valid  = 1'b1;
        raw_data_valid = 1'b1;
        packet_msg_rdy = 1'b1;
        @(negedge clk);
        msg_len_valid = 1'b0;
        #1;
        check("zero_err_pulse", DW'(zero_len_err), DW'(1));
        check("zero_len_rdy",   DW'(msg_len_rdy), DW'(1));
        check("zero_valid",     DW'(packet_msg_valid), DW'(0));
        check("zero_raw_rdy",   DW'(raw_data_rdy), DW'(0));
        @(negedge clk);
        #1;
        check("zero_err_clear", DW'(zero_len_err), DW'(0));
        check("zero_still_idle", DW'(msg_len_rdy), DW'(1));
        raw_data_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_packet(vecs[i].len, vecs[i].words, vecs[i].empty);

        // 48 bytes with an input bubble on word0 and backpressure on word1.
        send_desc(16'd48);
        raw_data_valid = 1'b0;
        packet_msg_rdy = 1'b1;
        #1;
        check("bubble_valid", DW'(packet_msg_valid), DW'(0));
        check("bubble_sop",   DW'(packet_msg_sop), DW'(0));
        check("bubble_eop",   DW'(packet_msg_eop), DW'(0));
        @(negedge clk);
        push_word(16'd48, 0, 3, 4'd0);
        raw_data_valid = 1'b1;
        raw_data_data  = pattern(16'd48, 1);
        packet_msg_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_valid",   DW'(packet_msg_valid), DW'(1));
            check("bp_data",    packet_msg_data, pattern(16'd48, 1));
            check("bp_sop",     DW'(packet_msg_sop), DW'(0));
            check("bp_eop",     DW'(packet_msg_eop), DW'(0));
            check("bp_raw_rdy", DW'(raw_data_rdy), DW'(0));
            @(negedge clk);
        end
        push_word(16'd48, 1, 3, 4'd0);
        push_word(16'd48, 2, 3, 4'd0);
        finish_pkt();

        // Reset mid-packet abandons it; the next packet starts with sop.
        send_desc(16'd64);
        push_word(16'd64, 0, 4, 4'd0);
        rst            = 1'b1;
        raw_data_valid = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_valid",   DW'(packet_msg_valid), DW'(0));
        check("midrst_len_rdy", DW'(msg_len_rdy), DW'(1));
        check("midrst_raw_rdy", DW'(raw_data_rdy), DW'(0));
        check("midrst_eop",     DW'(packet_msg_eop), DW'(0));
        rst            = 1'b0;
        raw_data_valid = 1'b0;
        @(negedge clk);
        run_packet(16'd16, 1, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_packetizer.md
AVALON_PACKETIZER -- requirements
Module: avalon_packetizer

Interface
REQ-001 Parameter DATA_WIDTH_IN_BYTES, default 16, sets the width of the data word in bytes; SHALL be a power of two and at least 2.
REQ-002 Parameter LEN_WIDTH, default 16, sets the width of the message-length field in bytes.
REQ-003 Derived constant EMPTY_W = log2(DATA_WIDTH_IN_BYTES); SHALL match the empty width of avalon_st_if.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 msg_len  input  LEN_WIDTH  message length in bytes for the next packet.
REQ-007 msg_len_valid  input  1  msg_len is valid.
REQ-008 msg_len_rdy  output  1  block accepts msg_len this cycle.
REQ-009 raw_data  avalon_st_if.slave  -  unframed data words (data/valid/rdy used; sop/eop/empty ignored).
REQ-010 packet_msg  avalon_st_if.master  -  framed Avalon-ST output (data/valid/sop/eop/empty, rdy from sink).
REQ-011 zero_len_err  output  1  one-cycle pulse: a zero-length descriptor was dropped.
REQ-012 pkt_done  output  1  one-cycle pulse, registered, the cycle after an eop transfer.

Function
REQ-013 States SHALL be IDLE and IN_MSG only.
REQ-014 IDLE: msg_len_rdy=1; raw_data.rdy=0; packet_msg.valid=0.
REQ-015 IDLE, msg_len_valid=1, msg_len=0: zero_len_err=1 next cycle; state stays IDLE; no output word.
REQ-016 IDLE, msg_len_valid=1, msg_len>0: latch words_left = ceil(msg_len/DATA_WIDTH_IN_BYTES) and last_empty = (DATA_WIDTH_IN_BYTES - msg_len mod DATA_WIDTH_IN_BYTES) mod DATA_WIDTH_IN_BYTES; set first flag; enter IN_MSG next cycle.
REQ-017 The ceil computation SHALL use LEN_WIDTH+1 bits internally, so msg_len = 2^LEN_WIDTH-1 does not overflow.
REQ-018 IN_MSG: msg_len_rdy=0; the data path SHALL be combinational with zero latency: packet_msg.valid=raw_data.valid, raw_data.rdy=packet_msg.rdy, packet_msg.data=raw_data.data.
REQ-019 IN_MSG: packet_msg.sop = first flag; packet_msg.eop = (words_left==1); packet_msg.empty = eop ? last_empty : 0.
REQ-020 Transfer is valid&&rdy on packet_msg; only transfers SHALL decrement words_left and clear the first flag.
REQ-021 Valid without rdy SHALL hold sop/eop/empty/words_left unchanged (backpressure safe).
REQ-022 Transfer with eop=1: next state IDLE, pkt_done=1 next cycle; one idle cycle SHALL separate consecutive packets.
REQ-023 Single-word packet: the same word SHALL carry sop=1 and eop=1.
REQ-024 Outputs sop, eop and empty SHALL be 0 whenever packet_msg.valid=0.
REQ-025 The block SHALL never emit sop without a later eop of the same packet unless reset intervenes.

Reset
REQ-026 rst=1 at a rising edge: state=IDLE, words_left=0, last_empty=0, first=0, zero_len_err=0, pkt_done=0.
REQ-027 Reset values: msg_len_rdy=1 (IDLE), packet_msg.valid/sop/eop=0, empty=0, raw_data.rdy=0.
REQ-028 Reset mid-packet SHALL abandon the packet without eop; the next accepted descriptor SHALL start with sop=1.

Verification (DATA_WIDTH_IN_BYTES=16, LEN_WIDTH=16)
REQ-029 msg_len=32, 2 raw words, rdy=1 -> word0 sop=1 eop=0 empty=0; word1 sop=0 eop=1 empty=0; pkt_done pulse next cycle.
REQ-030 msg_len=17 -> 2 words; word1 eop=1 empty=15. msg_len=5 -> 1 word with sop=1 eop=1 empty=11.
REQ-031 msg_len=0 with msg_len_valid=1 -> zero_len_err=1 for exactly one cycle; msg_len_rdy stays 1; packet_msg.valid stays 0.
REQ-032 msg_len=48, packet_msg.rdy=0 for 3 cycles on word1 -> valid=1 held, data stable, sop=0 eop=0; eop asserted only on word2 after release.
REQ-033 msg_len=64, rst=1 after word0 transfer -> next cycle valid=0, msg_len_rdy=1; then msg_len=16 -> single word with sop=1 eop=1 empty=0.
REQ-034 msg_len=65535 -> 4096 words; sop on word0 only; eop on word4095 with empty=1.
